// File: rtl/down_count_monitor.sv
// Lock/wrap/error monitor for a free-running 4-bit down-counter.
// Judges each step, tracks lock, counts wraps and lock losses.
module down_count_monitor #(
    parameter int LOCK_N = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [3:0]        cnt_in,
    output logic              locked,
    output logic              lost,
    output logic [1:0]        state,
    output logic              tick,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        ACQ  = 2'b00,
        LOCK = 2'b01,
        LOST = 2'b10
    } st_t;

    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    st_t               st_q;
    st_t               st_d;
    logic [3:0]        prev_q;
    logic              prev_vld_q;
    logic [3:0]        run_q;
    logic [3:0]        run_d;
    logic [3:0]        run_sat;
    logic [4:0]        run_inc;
    logic              legal;
    logic              wrap_step;
    logic              tick_d;
    logic              err_d;
    logic [WRAP_W-1:0] wrap_d;
    logic [ERR_W-1:0]  errc_d;

    assign legal     = prev_vld_q && (cnt_in == prev_q - 4'd1);
    assign wrap_step = (prev_q == 4'd0) && (cnt_in == 4'd15);
    assign run_inc   = {1'b0, run_q} + 5'd1;
    assign run_sat   = (run_q == 4'd15) ? 4'd15 : run_inc[3:0];

    always_comb begin
        st_d   = st_q;
        run_d  = run_q;
        tick_d = 1'b0;
        err_d  = 1'b0;
        wrap_d = wrap_cnt;
        errc_d = err_cnt;
        // the first sample after reset/clr only primes prev
        if (prev_vld_q) begin
            unique case (st_q)
                LOCK: begin
                    if (legal) begin
                        run_d = run_sat;
                        if (wrap_step) begin
                            tick_d = 1'b1;
                            wrap_d = wrap_cnt + 1'b1;
                        end
                    end else begin
                        st_d  = LOST;
                        run_d = 4'd0;
                        err_d = 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            errc_d = err_cnt + 1'b1;
                        end
                    end
                end
                ACQ, LOST: begin
                    if (!legal) begin
                        run_d = 4'd0;
                    end else if (run_inc == LOCK_TGT) begin
                        st_d  = LOCK;
                        run_d = 4'd0;
                    end else begin
                        run_d = run_sat;
                    end
                end
                default: begin
                    st_d  = ACQ;
                    run_d = 4'd0;
                end
            endcase
        end
        if (clr) begin
            st_d   = ACQ;
            run_d  = 4'd0;
            tick_d = 1'b0;
            err_d  = 1'b0;
            wrap_d = '0;
            errc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ACQ;
            prev_q     <= 4'd0;
            prev_vld_q <= 1'b0;
            run_q      <= 4'd0;
            tick       <= 1'b0;
            err        <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            st_q       <= st_d;
            prev_q     <= cnt_in;
            prev_vld_q <= ~clr;
            run_q      <= run_d;
            tick       <= tick_d;
            err        <= err_d;
            wrap_cnt   <= wrap_d;
            err_cnt    <= errc_d;
        end
    end

    assign state  = st_q;
    assign locked = (st_q == LOCK);
    assign lost   = (st_q == LOST);

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: directed scenarios plus random
// stimulus checked every cycle against a behavioural model.
module tb_down_count_monitor;

    localparam int LN = 4;
    localparam int WW = 3;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [3:0]    cnt_in = 4'd0;
    logic          locked;
    logic          lost;
    logic [1:0]    state;
    logic          tick;
    logic [WW-1:0] wrap_cnt;
    logic          err;
    logic [EW-1:0] err_cnt;

    down_count_monitor #(
        .LOCK_N(LN),
        .WRAP_W(WW),
        .ERR_W (EW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .cnt_in  (cnt_in),
        .locked  (locked),
        .lost    (lost),
        .state   (state),
        .tick    (tick),
        .wrap_cnt(wrap_cnt),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: mode 0 = acquiring, 1 = locked, 2 = lost
    int m_mode;
    int m_prev;
    bit m_vld;
    int m_streak;
    int m_wrap;
    int m_errc;
    bit m_tick;
    bit m_err;
    int cur;

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_prev = 0;
        m_vld = 0;
        m_streak = 0;
        m_wrap = 0;
        m_errc = 0;
        m_tick = 0;
        m_err = 0;
    endtask

    task automatic model_edge(input bit c, input int v);
        bit good;
        m_tick = 0;
        m_err = 0;
        if (c) begin
            model_reset();
        end else if (m_vld) begin
            good = (v == (m_prev + 15) % 16);
            if (m_mode == 1) begin
                if (good && m_prev == 0) begin
                    m_tick = 1;
                    m_wrap = (m_wrap + 1) % (1 << WW);
                end else if (!good) begin
                    m_mode = 2;
                    m_err = 1;
                    m_errc = (m_errc + 1 > (1 << EW) - 1) ? (1 << EW) - 1 : m_errc + 1;
                end
            end else if (good) begin
                m_streak++;
                if (m_streak == LN) begin
                    m_mode = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
        if (m_mode == 1) m_streak = 0;
        m_prev = v;
        m_vld = !c;
    endtask

    task automatic step(input bit c, input int v);
        clr = c;
        cnt_in = 4'(v);
        @(posedge clk);
        #1;
        model_edge(c, v);
        cur = v;
    endtask

    task automatic dec();
        step(0, (cur + 15) % 16);
    endtask

    task automatic rst_pulse();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wrap", int'(wrap_cnt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_errcnt", int'(err_cnt), 0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        vectors++;
        chk("locked", int'(locked), int'(m_mode == 1));
        chk("lost", int'(lost), int'(m_mode == 2));
        chk("state", int'(state), m_mode);
        chk("tick", int'(tick), int'(m_tick));
        chk("wrap_cnt", int'(wrap_cnt), m_wrap);
        chk("err", int'(err), int'(m_err));
        chk("err_cnt", int'(err_cnt), m_errc);
    end

    initial begin
        int r;
        model_reset();
        cur = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_wrap", int'(wrap_cnt), 0);
        rst = 1'b0;

        // acquire: 15 primes, 14..11 are four legal steps
        step(0, 15);
        step(0, 14);
        step(0, 13);
        step(0, 12);
        chk("t1_not_yet", int'(locked), 0);
        step(0, 11);
        chk("t1_locked", int'(locked), 1);
        chk("t1_state", int'(state), 1);

        // wrap
        while (cur != 0) dec();
        chk("t2_pre_wrap", int'(wrap_cnt), 0);
        step(0, 15);
        chk("t2_tick", int'(tick), 1);
        chk("t2_wrap", int'(wrap_cnt), 1);
        step(0, 14);
        chk("t2_tick_off", int'(tick), 0);

        // glitch and re-acquire
        while (cur != 7) dec();
        step(0, 6);
        step(0, 9);
        chk("t3_err", int'(err), 1);
        chk("t3_errcnt", int'(err_cnt), 1);
        chk("t3_state", int'(state), 2);
        chk("t3_locked", int'(locked), 0);
        step(0, 8);
        chk("t3_err_off", int'(err), 0);
        step(0, 7);
        step(0, 6);
        chk("t3_still_lost", int'(state), 2);
        step(0, 5);
        chk("t3_relock", int'(state), 1);

        // hold is illegal; then saturate the error counter
        step(0, cur);
        chk("t4_hold_state", int'(state), 2);
        chk("t4_hold_errcnt", int'(err_cnt), 2);
        for (int i = 0; i < 16; i++) begin
            repeat (LN) dec();
            step(0, cur);
        end
        chk("t4_sat", int'(err_cnt), 15);

        // clr on the wrap edge
        repeat (LN) dec();
        while (cur != 0) dec();
        chk("t5_locked", int'(locked), 1);
        step(1, 15);
        chk("t5_tick", int'(tick), 0);
        chk("t5_wrap", int'(wrap_cnt), 0);
        chk("t5_errcnt", int'(err_cnt), 0);
        chk("t5_state", int'(state), 0);
        step(0, 14);
        chk("t5_reload", int'(state), 0);
        step(0, 13);
        step(0, 12);
        step(0, 11);
        chk("t5_not_yet", int'(locked), 0);
        step(0, 10);
        chk("t5_relock", int'(locked), 1);

        // async reset while locked with three wraps
        repeat (48) dec();
        chk("t6_wrap3", int'(wrap_cnt), 3);
        rst_pulse();
        repeat (LN) dec();
        chk("t6_not_yet", int'(locked), 0);
        dec();
        chk("t6_relock", int'(locked), 1);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                rst_pulse();
            end else if (r < 5) begin
                step(1, int'($urandom_range(0, 15)));
            end else if (r < 16) begin
                step(0, int'($urandom_range(0, 15)));
            end else if (r < 24) begin
                step(0, cur);
            end else begin
                dec();
            end
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
